// File: rtl/vt52_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vt52_pkg
// Description : Shared byte constants, screen defaults, decoder state type
//               and coordinate clamp helper for the VT52 cursor controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vt52_pkg;

  // Default screen geometry
  localparam int DEFAULT_COLS = 80;
  localparam int DEFAULT_ROWS = 24;

  // Control bytes
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;

  // Escape command letters
  localparam logic [7:0] CH_UP    = 8'h41;  // 'A'
  localparam logic [7:0] CH_DOWN  = 8'h42;  // 'B'
  localparam logic [7:0] CH_RIGHT = 8'h43;  // 'C'
  localparam logic [7:0] CH_LEFT  = 8'h44;  // 'D'
  localparam logic [7:0] CH_HOME  = 8'h48;  // 'H'
  localparam logic [7:0] CH_LOAD  = 8'h59;  // 'Y'

  // Printable range and the bias applied to ESC Y coordinates
  localparam logic [7:0] PRINT_MIN    = 8'h20;
  localparam logic [7:0] PRINT_MAX    = 8'h7E;
  localparam logic [7:0] COORD_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_ESC       = 2'd1,
    ST_ESC_Y_ROW = 2'd2,
    ST_ESC_Y_COL = 2'd3
  } state_t;

  // Clamp a signed 9-bit intermediate into [0, max_v]
  function automatic logic [7:0] clamp_coord(input logic signed [8:0] v,
                                             input logic [7:0]        max_v);
    logic [7:0] result;
    if (v < 9'sd0) begin
      result = 8'd0;
    end else if (v > $signed({1'b0, max_v})) begin
      result = max_v;
    end else begin
      result = v[7:0];
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vt52_cursor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : vt52_cursor_ctrl_if
// Description : Byte stream valid/ready handshake from the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
interface vt52_cursor_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  // Byte source (UART side)
  modport master (output rx_data, output rx_valid, input rx_ready);
  // Byte sink (decoder side)
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface
`default_nettype wire

// File: rtl/vt52_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vt52_cursor_ctrl
// Description : VT52 byte-stream decoder. Turns printable bytes, CR/LF/BS and
//               ESC A/B/C/D/H/Y sequences into cursor register writes, frame
//               buffer write strobes and scroll requests.
// Revision    : 1.0 - initial release
// ============================================================================
module vt52_cursor_ctrl
  import vt52_pkg::*;
#(
  parameter int COLS     = DEFAULT_COLS,
  parameter int ROWS     = DEFAULT_ROWS,
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 5
) (
  input  wire logic                clk,
  input  wire logic                reset,
  vt52_cursor_ctrl_if.slave        rx,
  input  wire logic [COL_BITS-1:0] cur_col,
  input  wire logic [ROW_BITS-1:0] cur_row,
  output logic      [COL_BITS-1:0] new_col,
  output logic                     col_wen,
  output logic      [ROW_BITS-1:0] new_row,
  output logic                     row_wen,
  output logic      [7:0]          char_data,
  output logic      [COL_BITS-1:0] char_col,
  output logic      [ROW_BITS-1:0] char_row,
  output logic                     char_wen,
  output logic                     scroll_req,
  input  wire logic                scroll_busy
);

  localparam logic [7:0]          COL_MAX  = 8'(COLS - 1);
  localparam logic [7:0]          ROW_MAX  = 8'(ROWS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);

  state_t              state;
  logic                cooldown;
  logic [ROW_BITS-1:0] y_row;
  logic                accept;

  logic signed [8:0]   col_s;
  logic signed [8:0]   row_s;
  logic signed [8:0]   off_s;
  logic [COL_BITS-1:0] col_inc;
  logic [COL_BITS-1:0] col_dec;
  logic [ROW_BITS-1:0] row_inc;
  logic [ROW_BITS-1:0] row_dec;
  logic [COL_BITS-1:0] col_load;
  logic [ROW_BITS-1:0] row_load;

  // The cursor registers update one cycle after a write enable, so a second
  // byte is held off for one cycle after every accept.
  assign rx.rx_ready = !scroll_busy && !cooldown && reset;
  assign accept      = rx.rx_valid && rx.rx_ready;

  // Signed 9-bit cursor arithmetic with clamping, so nothing wraps
  always_comb begin
    col_s    = $signed(9'(cur_col));
    row_s    = $signed(9'(cur_row));
    off_s    = $signed({1'b0, rx.rx_data}) - $signed({1'b0, COORD_OFFSET});
    col_inc  = COL_BITS'(clamp_coord(col_s + 9'sd1, COL_MAX));
    col_dec  = COL_BITS'(clamp_coord(col_s - 9'sd1, COL_MAX));
    row_inc  = ROW_BITS'(clamp_coord(row_s + 9'sd1, ROW_MAX));
    row_dec  = ROW_BITS'(clamp_coord(row_s - 9'sd1, ROW_MAX));
    col_load = COL_BITS'(clamp_coord(off_s, COL_MAX));
    row_load = ROW_BITS'(clamp_coord(off_s, ROW_MAX));
  end

  // Decoder FSM with registered strobes and held position/character data
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_NORMAL;
      cooldown   <= 1'b0;
      y_row      <= '0;
      new_col    <= '0;
      col_wen    <= 1'b0;
      new_row    <= '0;
      row_wen    <= 1'b0;
      char_data  <= '0;
      char_col   <= '0;
      char_row   <= '0;
      char_wen   <= 1'b0;
      scroll_req <= 1'b0;
    end else begin
      col_wen    <= 1'b0;
      row_wen    <= 1'b0;
      char_wen   <= 1'b0;
      scroll_req <= 1'b0;
      cooldown   <= accept;

      if (accept) begin
        case (state)
          ST_NORMAL: begin
            if (rx.rx_data >= PRINT_MIN && rx.rx_data <= PRINT_MAX) begin
              char_wen  <= 1'b1;
              char_data <= rx.rx_data;
              char_col  <= cur_col;
              char_row  <= cur_row;
              new_col   <= col_inc;
              col_wen   <= 1'b1;
            end else begin
              case (rx.rx_data)
                CH_CR: begin
                  new_col <= '0;
                  col_wen <= 1'b1;
                end
                CH_LF: begin
                  // Bottom line: ask the scroller to move the screen instead
                  if (cur_row < ROW_LAST) begin
                    new_row <= row_inc;
                    row_wen <= 1'b1;
                  end else begin
                    scroll_req <= 1'b1;
                  end
                end
                CH_BS: begin
                  new_col <= col_dec;
                  col_wen <= 1'b1;
                end
                CH_ESC:  state <= ST_ESC;
                default: ;
              endcase
            end
          end

          ST_ESC: begin
            state <= ST_NORMAL;
            case (rx.rx_data)
              CH_UP: begin
                new_row <= row_dec;
                row_wen <= 1'b1;
              end
              CH_DOWN: begin
                new_row <= row_inc;
                row_wen <= 1'b1;
              end
              CH_RIGHT: begin
                new_col <= col_inc;
                col_wen <= 1'b1;
              end
              CH_LEFT: begin
                new_col <= col_dec;
                col_wen <= 1'b1;
              end
              CH_HOME: begin
                new_col <= '0;
                new_row <= '0;
                col_wen <= 1'b1;
                row_wen <= 1'b1;
              end
              CH_LOAD: state <= ST_ESC_Y_ROW;
              CH_ESC:  state <= ST_ESC;
              default: ;
            endcase
          end

          ST_ESC_Y_ROW: begin
            y_row <= row_load;
            state <= ST_ESC_Y_COL;
          end

          ST_ESC_Y_COL: begin
            new_col <= col_load;
            new_row <= y_row;
            col_wen <= 1'b1;
            row_wen <= 1'b1;
            state   <= ST_NORMAL;
          end

          default: state <= ST_NORMAL;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vt52_cursor_ctrl.md
Name: vt52_cursor_ctrl

Overview:
- Byte-stream command decoder sitting between the UART receive path and the cursor-position registers (one 8-bit register instance each for column and row).
- Consumes host bytes over a valid/ready handshake and decodes printable characters, CR/LF/BS and VT52 escape sequences (ESC A/B/C/D/H/Y).
- Drives next-position data plus write enables into the cursor registers, a character write strobe toward the frame buffer, and a scroll request.

Parameters:
- COLS, 80, screen columns
- ROWS, 24, screen rows
- COL_BITS, 7, column width (>= clog2(COLS))
- ROW_BITS, 5, row width (>= clog2(ROWS))

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid & rx_ready at a rising edge
- cur_col  in  COL_BITS  current column, from the column register
- cur_row  in  ROW_BITS  current row, from the row register
- new_col  out  COL_BITS  next column, to the column register idata
- col_wen  out  1  column register write enable
- new_row  out  ROW_BITS  next row, to the row register idata
- row_wen  out  1  row register write enable
- char_data  out  8  character to store
- char_col  out  COL_BITS  write column
- char_row  out  ROW_BITS  write row
- char_wen  out  1  frame-buffer write strobe
- scroll_req  out  1  one-cycle scroll-up pulse
- scroll_busy  in  1  scroller active; blocks acceptance

Behaviour:
- Reset (reset==0 at an edge): state NORMAL; every output 0; rx_ready 0 in that cycle. Reset mid-sequence discards any partial ESC/ESC Y.
- rx_ready = !scroll_busy & !cooldown & reset. cooldown is set for exactly one cycle after each accept, because cursor registers update one cycle after wen. Maximum throughput: 1 byte per 2 cycles.
- Outputs are registered. An accept at edge t drives wen/strobes high for the single cycle after t; they are 0 otherwise. new_*/char_* hold their last values while their enable is low.
- FSM states: NORMAL, ESC, ESC_Y_ROW, ESC_Y_COL.
- NORMAL:
  - 0x20-0x7E: char_wen with data at (cur_col, cur_row); new_col = cur_col+1, saturating at COLS-1 (no wrap); col_wen.
  - 0x0D (CR): new_col = 0, col_wen.
  - 0x0A (LF): if cur_row < ROWS-1, new_row = cur_row+1 with row_wen; else scroll_req pulse, no row_wen.
  - 0x08 (BS): new_col = cur_col-1, saturating at 0; col_wen.
  - 0x1B: go to ESC.
  - Other bytes (other controls, 0x7F-0xFF): ignored.
- ESC:
  - 'A': row-1, saturating at 0.
  - 'B': row+1, saturating at ROWS-1; never scrolls.
  - 'C': col+1, saturating at COLS-1.
  - 'D': col-1, saturating at 0.
  - 'H': col = 0 and row = 0, both wens.
  - 'Y': go to ESC_Y_ROW.
  - 0x1B: stay in ESC (restarts the sequence).
  - Any other byte: no effect.
  - All cases except 'Y' and 0x1B return to NORMAL.
- ESC_Y_ROW: latch row = byte-0x20, clamped to [0, ROWS-1] (bytes < 0x20 give 0); no output; go to ESC_Y_COL.
- ESC_Y_COL: col = byte-0x20, clamped to [0, COLS-1]; assert col_wen and row_wen together using the latched row; return to NORMAL.
- Arithmetic is done at 9 bits signed before clamping; no truncation wrap.
- A saturating move still asserts wen, even when the value is unchanged.
- scroll_busy rising while a command is pending does not cancel that command's outputs.

Decomposition:
- Shared package vt52_pkg:
  - Byte constants: ESC, CR, LF, BS, the command letters, COORD_OFFSET = 0x20.
  - Default COLS/ROWS.
  - Enumerated state type.
- No sub-module. The cursor registers stay external, instantiated by the parent.

Test Plan:
- Reset low 3 cycles, then high with cur=(0,0); send 'A' -> char_wen=1, char_data=0x41 at (0,0); new_col=1, col_wen=1 for one cycle; rx_ready low the cycle after accept.
- ESC 'Y' 0x25 0x2A -> only the final byte produces outputs: row_wen=col_wen=1, new_row=5, new_col=10; ESC 'Y' 0x7F 0x7F -> (23,79) clamped.
- cur=(79,23): send 'Z' -> char written at (79,23), new_col=79; LF -> scroll_req=1, row_wen=0.
- cur=(0,0): BS -> new_col=0, col_wen=1; ESC 'A' -> new_row=0; ESC 'H' from (40,12) -> (0,0).
- Send ESC 'Y' 0x25, then reset low one cycle, then 0x2A -> state NORMAL; 0x2A written as '*' at the current cursor; no coordinate load.
- scroll_busy=1 with rx_valid=1 -> rx_ready=0, no outputs; drop scroll_busy -> byte accepted next edge; ESC 'Q' -> no outputs, next 'B' treated as printable.
